// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// slave = arbiter view; master = requesters plus memory read-data source.
interface dmem_arbiter_if;
  logic        p0_req_i;
  logic        p0_we_i;
  logic [31:0] p0_addr_i;
  logic [3:0]  p0_be_i;
  logic [31:0] p0_wdata_i;
  logic        p0_done_o;
  logic        p0_err_o;
  logic [31:0] p0_rdata_o;

  logic        p1_req_i;
  logic        p1_we_i;
  logic [31:0] p1_addr_i;
  logic [3:0]  p1_be_i;
  logic [31:0] p1_wdata_i;
  logic        p1_done_o;
  logic        p1_err_o;
  logic [31:0] p1_rdata_o;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_be_i, p0_wdata_i,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i,
    output p0_done_o, p0_err_o, p0_rdata_o,
    output p1_done_o, p1_err_o, p1_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
    input  mem_rdata_i
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_be_i, p0_wdata_i,
    output p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i,
    input  p0_done_o, p0_err_o, p0_rdata_o,
    input  p1_done_o, p1_err_o, p1_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory word port; partial stores become read-modify-write.
// Done 2 cycles after grant (3 for partial stores, 1 for out-of-range); losers wait with req held.
module dmem_arbiter #(
  parameter int MEM_BYTES = 32
) (
  input logic           clk_i,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        last, gnt, sel, any_req, range_err;
  logic        we_q, err_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, merged_q, rdata0_q, rdata1_q;
  logic [31:0] sel_addr, merge_word;

  assign any_req   = bus.p0_req_i | bus.p1_req_i;
  // On a tie the port not granted last wins; otherwise whichever port is asking.
  assign sel       = (bus.p0_req_i & bus.p1_req_i) ? ~last : bus.p1_req_i;
  assign sel_addr  = sel ? bus.p1_addr_i : bus.p0_addr_i;
  assign range_err = sel_addr > 32'(MEM_BYTES - 4);

  always_comb begin
    merge_word = bus.mem_rdata_i;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merge_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_re_o    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = range_err ? RESP : ACCESS;
      end
      ACCESS: begin
        state_nxt = RESP;
        if (!we_q) begin
          bus.mem_addr_o = addr_q;
          bus.mem_re_o   = 1'b1;
        end else if (be_q == 4'hF) begin
          bus.mem_addr_o  = addr_q;
          bus.mem_we_o    = 1'b1;
          bus.mem_wdata_o = wdata_q;
        end else if (be_q != 4'h0) begin
          bus.mem_addr_o = addr_q;
          bus.mem_re_o   = 1'b1;
          state_nxt      = MERGE_WR;
        end
      end
      MERGE_WR: begin
        bus.mem_addr_o  = addr_q;
        bus.mem_we_o    = 1'b1;
        bus.mem_wdata_o = merged_q;
        state_nxt       = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      last     <= 1'b1;
      gnt      <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= sel;
            last    <= sel;
            we_q    <= sel ? bus.p1_we_i : bus.p0_we_i;
            addr_q  <= {sel_addr[31:2], 2'b00};
            be_q    <= sel ? bus.p1_be_i : bus.p0_be_i;
            wdata_q <= sel ? bus.p1_wdata_i : bus.p0_wdata_i;
            err_q   <= range_err;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (gnt) rdata1_q <= bus.mem_rdata_i;
            else     rdata0_q <= bus.mem_rdata_i;
          end else begin
            merged_q <= merge_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p0_done_o  = (state == RESP) & ~gnt;
  assign bus.p1_done_o  = (state == RESP) & gnt;
  assign bus.p0_err_o   = bus.p0_done_o & err_q;
  assign bus.p1_err_o   = bus.p1_done_o & err_q;
  assign bus.p0_rdata_o = rdata0_q;
  assign bus.p1_rdata_o = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives dmem_arbiter through directed and random transactions against a transaction-level model
// of the memory contents, arbitration order and per-transaction latency/strobe counts.
module tb_dmem_arbiter;
  logic clk_i = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;

  dmem_arbiter_if bus ();
  dmem_arbiter #(.MEM_BYTES(32)) dut (.clk_i(clk_i), .reset(reset), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Memory: combinational read, full-word write on the clock, cleared by reset.
  logic [31:0] mem_arr [8];
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
    end else if (bus.mem_we_o) begin
      mem_arr[bus.mem_addr_o[4:2]] <= bus.mem_wdata_o;
    end
  end
  assign bus.mem_rdata_i = mem_arr[bus.mem_addr_o[4:2]];

  // Reference model state.
  logic [31:0] ref_mem [8];
  logic [31:0] ref_rdata [2];
  int          ref_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_last = 1;
  endtask

  task automatic drive(input int port, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    if (port == 0) begin
      bus.p0_req_i = req; bus.p0_we_i = we; bus.p0_addr_i = addr; bus.p0_be_i = be; bus.p0_wdata_i = wdata;
    end else begin
      bus.p1_req_i = req; bus.p1_we_i = we; bus.p1_addr_i = addr; bus.p1_be_i = be; bus.p1_wdata_i = wdata;
    end
  endtask

  function automatic logic done_of(input int port);
    return (port == 0) ? bus.p0_done_o : bus.p1_done_o;
  endfunction

  function automatic logic err_of(input int port);
    return (port == 0) ? bus.p0_err_o : bus.p1_err_o;
  endfunction

  function automatic logic [31:0] rdata_of(input int port);
    return (port == 0) ? bus.p0_rdata_o : bus.p1_rdata_o;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, bus.p0_done_o, bus.p1_done_o, bus.p0_err_o, bus.p1_err_o,
                          bus.mem_we_o, bus.mem_re_o}, 32'd0);
    check({tag, "_p0_rdata"}, bus.p0_rdata_o, 32'd0);
    check({tag, "_p1_rdata"}, bus.p1_rdata_o, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
  endtask

  // One transaction on one port, called with the DUT idle, #1 after a clock edge.
  task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    int          idx, exp_lat, exp_re, exp_we, cyc, nre, nwe, bad, other;
    logic        exp_err, seen;
    logic [31:0] exp_wd, exp_addr, wd;
    string       t;
    txn_no++;
    t = $sformatf("txn%0d_p%0d", txn_no, port);
    idx = int'(addr[4:2]);
    exp_err  = addr > 32'd28;
    exp_addr = {addr[31:2], 2'b00};
    exp_re = 0; exp_we = 0; exp_wd = '0;
    if (exp_err) exp_lat = 1;
    else if (!we) begin exp_lat = 2; exp_re = 1; end
    else if (be == 4'hF) begin exp_lat = 2; exp_we = 1; exp_wd = wdata; end
    else if (be == 4'h0) exp_lat = 2;
    else begin
      exp_lat = 3; exp_re = 1; exp_we = 1;
      for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = be[b] ? wdata[8*b +: 8] : ref_mem[idx][8*b +: 8];
    end

    drive(port, 1'b1, we, addr, be, wdata);
    cyc = 0; nre = 0; nwe = 0; bad = 0; other = 0; seen = 1'b0; wd = '0;
    while (!seen && cyc < 8) begin
      @(posedge clk_i); #1;
      cyc++;
      if (bus.mem_re_o) nre++;
      if (bus.mem_we_o) begin nwe++; wd = bus.mem_wdata_o; end
      if (bus.mem_re_o && bus.mem_we_o) bad++;
      if ((bus.mem_re_o || bus.mem_we_o) && bus.mem_addr_o !== exp_addr) bad++;
      if (!bus.mem_re_o && !bus.mem_we_o && (bus.mem_addr_o !== '0 || bus.mem_wdata_o !== '0)) bad++;
      if (bus.mem_re_o && bus.mem_wdata_o !== '0) bad++;
      if (done_of(1 - port)) other++;
      if (done_of(port)) seen = 1'b1;
    end
    check({t, "_done"}, 32'(seen), 32'd1);
    check({t, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({t, "_err"}, 32'(err_of(port)), 32'(exp_err));
    check({t, "_re_cycles"}, 32'(nre), 32'(exp_re));
    check({t, "_we_cycles"}, 32'(nwe), 32'(exp_we));
    if (exp_we != 0) check({t, "_wdata"}, wd, exp_wd);
    check({t, "_strobe_rules"}, 32'(bad), 32'd0);
    check({t, "_other_done"}, 32'(other), 32'd0);

    if (!exp_err) begin
      if (!we) ref_rdata[port] = ref_mem[idx];
      else if (exp_we != 0) ref_mem[idx] = exp_wd;
    end
    ref_last = port;
    check({t, "_rdata"}, rdata_of(port), ref_rdata[port]);
    check({t, "_other_rdata"}, rdata_of(1 - port), ref_rdata[1 - port]);

    drive(port, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk_i); #1;
    check({t, "_done_one_cycle"}, 32'(done_of(port)), 32'd0);
  endtask

  initial begin
    int w, exp_port;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i) reset = 1'b0;
    @(posedge clk_i); #1;
    check_all_zero("idle_after_reset");

    // Full store then load; partial store from port 1 then load.
    run_txn(0, 1'b1, 32'd8, 4'hF, 32'hDEADBEEF);
    run_txn(0, 1'b0, 32'd8, 4'h0, 32'h0);
    check("load_deadbeef", bus.p0_rdata_o, 32'hDEADBEEF);
    run_txn(1, 1'b1, 32'd8, 4'b0011, 32'h000055AA);
    run_txn(1, 1'b0, 32'd8, 4'h0, 32'h0);
    check("load_merged", bus.p1_rdata_o, 32'hDEAD55AA);

    // Both ports loading continuously: grants alternate starting with the port not granted last.
    w = 1 - ref_last;
    drive(0, 1'b1, 1'b0, 32'd8, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd12, 4'h0, 32'h0);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk_i); #1;
      exp_port = (c % 3 != 2) ? -1 : (((c / 3) % 2 == 0) ? w : 1 - w);
      check($sformatf("rr_c%0d_p0_done", c), 32'(bus.p0_done_o), 32'(exp_port == 0));
      check($sformatf("rr_c%0d_p1_done", c), 32'(bus.p1_done_o), 32'(exp_port == 1));
      if (exp_port >= 0) begin
        ref_rdata[exp_port] = ref_mem[(exp_port == 0) ? 2 : 3];
        check($sformatf("rr_c%0d_rdata", c), rdata_of(exp_port), ref_rdata[exp_port]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    ref_last = 1 - w;
    @(posedge clk_i); #1;

    // Out-of-range accesses, address alignment, empty store.
    run_txn(0, 1'b0, 32'd29, 4'h0, 32'h0);
    run_txn(0, 1'b0, 32'h100, 4'h0, 32'h0);
    run_txn(0, 1'b0, 32'h0B, 4'h0, 32'h0);
    check("aligned_load", bus.p0_rdata_o, 32'hDEAD55AA);
    run_txn(1, 1'b1, 32'd4, 4'h0, 32'hFFFFFFFF);
    run_txn(1, 1'b0, 32'd4, 4'h0, 32'h0);

    // Reset while a partial store is in ACCESS.
    drive(0, 1'b1, 1'b1, 32'h10, 4'b0100, 32'h00AB0000);
    @(posedge clk_i); #1;
    check("rst_in_access_re", 32'(bus.mem_re_o), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_no_done", 32'(bus.p0_done_o | bus.p1_done_o), 32'd0);
    model_reset();
    @(negedge clk_i) reset = 1'b0;
    @(posedge clk_i); #1;
    run_txn(0, 1'b1, 32'h10, 4'h0, 32'h12345678);
    run_txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
    check("rst_mem_cleared", bus.p0_rdata_o, 32'd0);

    // Random single-port traffic.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 31));
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
              4'($urandom_range(0, 15)), $urandom);
    end
    for (int i = 0; i < 8; i++) check($sformatf("final_mem%0d", i), mem_arr[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
